// File: rtl/seq_pkg.sv
// Shared definitions for the function sequencer.
// Holds the sequencer state encoding, the word widths used by the
// simple8BitProcessor interface, and the default idle func encoding.
package seq_pkg;

    localparam int FUNC_W = 9;               // {opCode, Rx, Ry}
    localparam int DATA_W = 8;               // processor data path
    localparam int WORD_W = FUNC_W + DATA_W; // one program slot: {func, imm}

    // Decodes to regWrite=0 in the processor, so it is safe to drive between runs.
    localparam logic [FUNC_W-1:0] IDLE_FUNC_DEFAULT = 9'h000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } seq_state_e;

endpackage

// File: rtl/func_program_mem.sv
// Program storage for the function sequencer.
// DEPTH x WORD_W register array with one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports:
//   clock  - write clock
//   we     - write enable
//   waddr  - write slot
//   wdata  - {func, imm} word to store
//   raddr  - read slot
//   rdata  - {func, imm} word at raddr (combinational)
module func_program_mem
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/func_sequencer.sv
// Program sequencer for simple8BitProcessor.
// Holds a loadable program of (func, immediate) pairs; on start it drives them
// onto the processor func/dataIn one per clock, then captures processor dataOut
// into result and pulses done.
// Ports:
//   clock, resetN           - clock, asynchronous active-low reset
//   loadEn/loadAddr/
//   loadFunc/loadImm        - program slot write (ignored while busy)
//   progLen                 - instruction count, sampled on start
//   start, pause, abort     - run control (abort has top priority)
//   funcOut, procDataIn     - to processor func / dataIn
//   procDataOut             - from processor dataOut
//   result, done            - captured dataOut and its one-cycle valid pulse
//   busy, pc                - run status and current/next slot
module func_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned       DEPTH     = 16,
    parameter int unsigned       AW        = 4,
    parameter logic [FUNC_W-1:0] IDLE_FUNC = IDLE_FUNC_DEFAULT
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              loadEn,
    input  logic [AW-1:0]     loadAddr,
    input  logic [FUNC_W-1:0] loadFunc,
    input  logic [DATA_W-1:0] loadImm,
    input  logic [AW:0]       progLen,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    output logic [FUNC_W-1:0] funcOut,
    output logic [DATA_W-1:0] procDataIn,
    input  logic [DATA_W-1:0] procDataOut,
    output logic [DATA_W-1:0] result,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     pc
);

    seq_state_e        state_q, state_d;
    logic [AW:0]       cnt_q, cnt_d;     // instructions issued; low bits are pc
    logic [AW:0]       len_q, len_d;
    logic [FUNC_W-1:0] func_q, func_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              mem_we;
    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] first_word;

    assign mem_we = loadEn && (state_q == S_IDLE);

    func_program_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (loadAddr),
        .wdata ({loadFunc, loadImm}),
        .raddr (cnt_q[AW-1:0]),
        .rdata (rd_word)
    );

    // The first word is issued on the start edge itself. A slot-0 write in the
    // same cycle has not reached the array yet, so forward it.
    assign first_word = (loadEn && (loadAddr == '0)) ? {loadFunc, loadImm} : rd_word;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        func_d   = func_q;
        din_d    = din_q;
        result_d = result_q;
        done_d   = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            func_d  = IDLE_FUNC;
            din_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (progLen == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = S_RUN;
                            len_d   = progLen;
                            func_d  = first_word[WORD_W-1:DATA_W];
                            din_d   = first_word[DATA_W-1:0];
                            cnt_d   = (AW+1)'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (cnt_q == len_q) begin
                        // Last word has been on the bus for a cycle; let it execute.
                        state_d = S_DRAIN;
                        func_d  = IDLE_FUNC;
                        din_d   = '0;
                    end else if (pause) begin
                        func_d = IDLE_FUNC;
                        din_d  = '0;
                    end else begin
                        func_d = rd_word[WORD_W-1:DATA_W];
                        din_d  = rd_word[DATA_W-1:0];
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    state_d  = S_IDLE;
                    result_d = procDataOut;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    func_d   = IDLE_FUNC;
                    din_d    = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    func_d  = IDLE_FUNC;
                    din_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            func_q   <= IDLE_FUNC;
            din_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            func_q   <= func_d;
            din_q    <= din_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign funcOut    = func_q;
    assign procDataIn = din_q;
    assign result     = result_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pc         = cnt_q[AW-1:0];

endmodule

// File: tb/tb_func_sequencer.sv
module tb_func_sequencer;

    logic       clock = 1'b0;
    logic       resetN;
    logic       loadEn;
    logic [3:0] loadAddr;
    logic [8:0] loadFunc;
    logic [7:0] loadImm;
    logic [4:0] progLen;
    logic       start;
    logic       pause;
    logic       abort;
    logic [8:0] funcOut;
    logic [7:0] procDataIn;
    logic [7:0] procDataOut;
    logic [7:0] result;
    logic       busy;
    logic       done;
    logic [3:0] pc;

    int n_tests = 0;
    int n_fail  = 0;

    func_sequencer #(.DEPTH(16), .AW(4), .IDLE_FUNC(9'h000)) dut (
        .clock       (clock),
        .resetN      (resetN),
        .loadEn      (loadEn),
        .loadAddr    (loadAddr),
        .loadFunc    (loadFunc),
        .loadImm     (loadImm),
        .progLen     (progLen),
        .start       (start),
        .pause       (pause),
        .abort       (abort),
        .funcOut     (funcOut),
        .procDataIn  (procDataIn),
        .procDataOut (procDataOut),
        .result      (result),
        .busy        (busy),
        .done        (done),
        .pc          (pc)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [8:0] f, input logic [7:0] i);
        loadEn = 1'b1; loadAddr = a; loadFunc = f; loadImm = i;
        tick();
        loadEn = 1'b0;
    endtask

    task automatic chk_word(input string tag, input logic [8:0] f, input logic [7:0] i);
        chk({tag, "_func"}, 32'(funcOut), 32'(f));
        chk({tag, "_imm"},  32'(procDataIn), 32'(i));
    endtask

    int done_cnt;

    initial begin
        resetN = 1'b0; loadEn = 1'b0; loadAddr = '0; loadFunc = '0; loadImm = '0;
        progLen = '0; start = 1'b0; pause = 1'b0; abort = 1'b0; procDataOut = 8'h00;

        // ---------------- reset state
        tick(); tick();
        chk("rst_func",   32'(funcOut), 32'h000);
        chk("rst_din",    32'(procDataIn), 32'h00);
        chk("rst_result", 32'(result), 32'h00);
        chk("rst_busy",   32'(busy), 32'h0);
        chk("rst_done",   32'(done), 32'h0);
        chk("rst_pc",     32'(pc), 32'h0);
        resetN = 1'b1;
        tick();

        // ---------------- basic 3-instruction run
        load(4'd0, 9'h0C8, 8'h05);
        load(4'd1, 9'h0D1, 8'h03);
        load(4'd2, 9'h111, 8'h00);
        procDataOut = 8'h5A;
        progLen = 5'd3; start = 1'b1;
        tick(); start = 1'b0;
        chk_word("b_c1", 9'h0C8, 8'h05);
        chk("b_c1_busy", 32'(busy), 32'h1);
        chk("b_c1_pc",   32'(pc), 32'h1);
        tick();
        chk_word("b_c2", 9'h0D1, 8'h03);
        tick();
        chk_word("b_c3", 9'h111, 8'h00);
        chk("b_c3_done", 32'(done), 32'h0);
        tick();
        chk_word("b_c4", 9'h000, 8'h00);
        chk("b_c4_busy", 32'(busy), 32'h1);
        chk("b_c4_done", 32'(done), 32'h0);
        tick();
        chk("b_c5_done",   32'(done), 32'h1);
        chk("b_c5_result", 32'(result), 32'h5A);
        chk("b_c5_busy",   32'(busy), 32'h0);
        chk("b_c5_pc",     32'(pc), 32'h0);
        tick();
        chk("b_c6_done", 32'(done), 32'h0);

        // ---------------- zero-length start
        procDataOut = 8'h99;
        progLen = 5'd0; start = 1'b1;
        tick(); start = 1'b0;
        chk("z_done",   32'(done), 32'h1);
        chk("z_busy",   32'(busy), 32'h0);
        chk("z_func",   32'(funcOut), 32'h000);
        chk("z_result", 32'(result), 32'h5A);
        tick();
        chk("z_done2", 32'(done), 32'h0);

        // ---------------- pause: 4 instructions, 3 paused cycles
        load(4'd3, 9'h1A3, 8'h77);
        procDataOut = 8'hC3;
        progLen = 5'd4; start = 1'b1;
        tick(); start = 1'b0;
        chk_word("p_c1", 9'h0C8, 8'h05);
        tick();
        chk_word("p_c2", 9'h0D1, 8'h03);
        pause = 1'b1;
        for (int k = 3; k <= 5; k++) begin
            tick();
            chk_word($sformatf("p_c%0d", k), 9'h000, 8'h00);
            chk($sformatf("p_c%0d_pc", k), 32'(pc), 32'h2);
            chk($sformatf("p_c%0d_busy", k), 32'(busy), 32'h1);
        end
        pause = 1'b0;
        tick();
        chk_word("p_c6", 9'h111, 8'h00);
        tick();
        chk_word("p_c7", 9'h1A3, 8'h77);
        tick();
        chk("p_c8_done", 32'(done), 32'h0);
        chk("p_c8_busy", 32'(busy), 32'h1);
        tick();
        chk("p_c9_done",   32'(done), 32'h1);
        chk("p_c9_result", 32'(result), 32'hC3);

        // ---------------- abort during 2nd instruction, then rerun
        procDataOut = 8'h11;
        progLen = 5'd3; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        chk_word("a_c2", 9'h0D1, 8'h03);
        abort = 1'b1;
        tick(); abort = 1'b0;
        chk_word("a_c3", 9'h000, 8'h00);
        chk("a_c3_busy", 32'(busy), 32'h0);
        chk("a_c3_pc",   32'(pc), 32'h0);
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (done) done_cnt++;
            tick();
        end
        chk("a_nodone", 32'(done_cnt), 32'h0);
        chk("a_result", 32'(result), 32'hC3);
        progLen = 5'd3; start = 1'b1;
        tick(); start = 1'b0;
        chk_word("a_rerun_c1", 9'h0C8, 8'h05);
        tick(); tick(); tick(); tick();
        chk("a_rerun_done",   32'(done), 32'h1);
        chk("a_rerun_result", 32'(result), 32'h11);

        // ---------------- full-depth run, same-cycle load+start, writes while busy
        for (int i = 0; i < 16; i++) load(4'(i), 9'h040 + 9'(i), 8'h20 + 8'(i));
        procDataOut = 8'h6E;
        loadEn = 1'b1; loadAddr = 4'd0; loadFunc = 9'h1FF; loadImm = 8'hEE;
        progLen = 5'd16; start = 1'b1;
        tick(); loadEn = 1'b0; start = 1'b0;
        done_cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 1) chk_word("d_c1", 9'h1FF, 8'hEE);
            else chk_word($sformatf("d_c%0d", k), 9'h040 + 9'(k - 1), 8'h20 + 8'(k - 1));
            chk($sformatf("d_c%0d_pc", k), 32'(pc), 32'(k % 16));
            chk($sformatf("d_c%0d_busy", k), 32'(busy), 32'h1);
            if (done) done_cnt++;
            if (k == 3) begin
                loadEn = 1'b1; loadAddr = 4'd5; loadFunc = 9'h0AA; loadImm = 8'h55;
                progLen = 5'd2; start = 1'b1;
            end else begin
                loadEn = 1'b0; start = 1'b0;
            end
            tick();
        end
        chk_word("d_c17", 9'h000, 8'h00);
        chk("d_c17_busy", 32'(busy), 32'h1);
        tick();
        chk("d_c18_done",   32'(done), 32'h1);
        chk("d_c18_result", 32'(result), 32'h6E);
        chk("d_c18_pc",     32'(pc), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done) done_cnt++;
        end
        chk("d_single_done", 32'(done_cnt), 32'h0);

        // ---------------- asynchronous reset mid-run
        progLen = 5'd4; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        resetN = 1'b0;
        #1;
        chk("r_busy",   32'(busy), 32'h0);
        chk("r_func",   32'(funcOut), 32'h000);
        chk("r_pc",     32'(pc), 32'h0);
        chk("r_result", 32'(result), 32'h00);
        tick();
        resetN = 1'b1;
        tick();
        chk("r_after_busy", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
